// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family (sync and async variants).
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_ADDR_W_DEF = 8;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Number of storage entries addressed by addr_w bits
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Latency: write lands on the clock edge; read data is combinational from rd_addr.
// Backpressure: none; the caller gates wr_en.
//   clk_in   : write clock
//   wr_en    : write strobe, wr_addr/wr_dat sampled on rising edge
//   rd_addr  : read address, rd_dat follows combinationally
module fifo_ram_dp
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
    input  logic              clk_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    // Contents are deliberately not reset; empty gating hides stale entries
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read.
// Latency: std mode data 1 cycle after rd; FWFT head word visible 1 cycle after write.
// Backpressure: writes dropped while full, reads dropped while empty; sticky error flags record both.
//   clk_in/rst        : clock, asynchronous active-low reset
//   d_in/wr, rd       : write data + request, read request
//   clr_err           : clears overflow/underflow (a same-cycle set wins)
//   d_out             : read data
//   empty/full/almost_full/almost_empty/count : occupancy status
//   overflow/underflow: sticky error flags
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W_DEF,
    parameter int ADDR_W   = FIFO_ADDR_W_DEF,
    parameter int AF_LEVEL = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FIFO_MODE_STD
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_in,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr_err,
    output logic [DATA_W-1:0] d_out,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT  = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rd_dat;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empty;

    fifo_ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_in  (clk_in),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_dat  (d_in),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_dat  (ram_rd_dat)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
        // Set has priority over clear so no error event is ever lost
        overflow_d  = (wr & full)  | (overflow_q  & ~clr_err);
        underflow_d = (rd & empty) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head of queue shown directly; zero while empty so stale memory never leaks
            assign d_out = empty ? '0 : ram_rd_dat;
        end else begin : g_std
            logic [DATA_W-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_acc) dout_d = ram_rd_dat;
            end

            always_ff @(posedge clk_in or negedge rst) begin
                if (!rst) dout_q <= '0;
                else      dout_q <= dout_d;
            end

            assign d_out = dout_q;
        end
    endgenerate

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a standard-read and an FWFT instance driven in lockstep.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_sync_param;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk, rst_n;
    logic [DW-1:0] din_i;
    logic          wr_i, rd_i, clr_i;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
    logic          f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [AW:0]   s_count, f_count;

    fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(2), .AE_LEVEL(1), .FWFT(0)) u_std (
        .clk_in(clk), .rst(rst_n), .d_in(din_i), .wr(wr_i), .rd(rd_i), .clr_err(clr_i),
        .d_out(s_dout), .empty(s_empty), .full(s_full), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(2), .AE_LEVEL(1), .FWFT(1)) u_fwft (
        .clk_in(clk), .rst(rst_n), .d_in(din_i), .wr(wr_i), .rd(rd_i), .clr_err(clr_i),
        .d_out(f_dout), .empty(f_empty), .full(f_full), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of stored words plus expected flags and std-mode output
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_ovf, exp_unf;
    int            n_cmp, n_fail;

    function automatic logic [7:0] exp_status();
        int n;
        n = q.size();
        // {count[2:0], empty, full, almost_full, almost_empty, pad}
        return {3'(n), (n == 0), (n == DEPTH), (n >= 2), (n <= 1), 1'b0};
    endfunction

    function automatic logic [DW-1:0] exp_head();
        return (q.size() == 0) ? '0 : q[0];
    endfunction

    // One clock of stimulus; model updated with pre-edge full/empty
    task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        bit was_full, was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        din_i = d; wr_i = w; rd_i = r; clr_i = c;
        @(posedge clk);
        if (r && !was_empty) exp_dout = q.pop_front();
        if (w && !was_full)  q.push_back(d);
        exp_ovf = (w && was_full)  || (exp_ovf && !c);
        exp_unf = (r && was_empty) || (exp_unf && !c);
        #1;
        wr_i = 1'b0; rd_i = 1'b0; clr_i = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({s_count, s_empty, s_full, s_af, s_ae, 1'b0} !== exp_status() ||
            {f_count, f_empty, f_full, f_af, f_ae, 1'b0} !== exp_status()) begin
            n_fail++;
            $display("FAIL reset_status: std=%b fwft=%b want=%b",
                     {s_count, s_empty, s_full, s_af, s_ae, 1'b0},
                     {f_count, f_empty, f_full, f_af, f_ae, 1'b0}, exp_status());
        end
        n_cmp++;
        if ({s_ovf, s_unf, f_ovf, f_unf} !== 4'b0 || s_dout !== 8'h00 || f_dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags_data: flags=%b sd=%h fd=%h want 0000/00/00",
                     {s_ovf, s_unf, f_ovf, f_unf}, s_dout, f_dout);
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (vals[i]) begin
            step(1, 0, 0, vals[i]);
            n_cmp++;
            if ({s_count, s_empty, s_full, s_af, s_ae, 1'b0} !== exp_status() || f_dout !== exp_head()) begin
                n_fail++;
                $display("FAIL fill_%0d: status=%b fd=%h want %b/%h", i,
                         {s_count, s_empty, s_full, s_af, s_ae, 1'b0}, f_dout, exp_status(), exp_head());
            end
        end
        n_cmp++;
        if (s_count !== 3'd4 || s_full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_full: count=%0d full=%b want 4/1", s_count, s_full);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00);
            n_cmp++;
            if (s_dout !== exp_dout || f_dout !== exp_head() ||
                {s_count, s_empty, s_full, s_af, s_ae, 1'b0} !== exp_status()) begin
                n_fail++;
                $display("FAIL drain_%0d: sd=%h fd=%h status=%b want %h/%h/%b", i, s_dout, f_dout,
                         {s_count, s_empty, s_full, s_af, s_ae, 1'b0}, exp_dout, exp_head(), exp_status());
            end
        end
        n_cmp++;
        if (s_dout !== 8'h44 || s_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_last: sd=%h empty=%b want 44/1", s_dout, s_empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'hA0 + 8'(i));
        step(1, 0, 0, 8'h55);
        n_cmp++;
        if (s_ovf !== 1'b1 || f_ovf !== 1'b1 || s_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b/%b count=%0d want 1/1/4", s_ovf, f_ovf, s_count);
        end
        step(0, 0, 1, 8'h00);
        n_cmp++;
        if (s_ovf !== 1'b0 || f_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: ovf=%b/%b want 0/0", s_ovf, f_ovf);
        end
        step(1, 0, 1, 8'h66);
        n_cmp++;
        if (s_ovf !== exp_ovf || s_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: ovf=%b want 1", s_ovf);
        end
        // Draining shows the rejected writes never corrupted storage
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00);
            n_cmp++;
            if (s_dout !== exp_dout || s_dout !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_data_%0d: sd=%h want %h", i, s_dout, exp_dout);
            end
        end
        step(0, 0, 1, 8'h00);
    endtask

    task automatic test_underflow();
        step(0, 1, 0, 8'h00);
        n_cmp++;
        if (s_unf !== 1'b1 || f_unf !== 1'b1 || s_dout !== exp_dout || s_dout !== 8'hA3) begin
            n_fail++;
            $display("FAIL unf_set: unf=%b/%b sd=%h want 1/1/a3", s_unf, f_unf, s_dout);
        end
        step(1, 1, 0, 8'hA5);
        n_cmp++;
        if (s_count !== 3'd1 || s_empty !== 1'b0 || f_dout !== 8'hA5 || s_dout !== 8'hA3) begin
            n_fail++;
            $display("FAIL unf_wr_rd: count=%0d empty=%b fd=%h sd=%h want 1/0/a5/a3",
                     s_count, s_empty, f_dout, s_dout);
        end
        step(0, 1, 1, 8'h00);
        n_cmp++;
        if (s_dout !== 8'hA5 || s_unf !== 1'b0 || s_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL unf_readback: sd=%h unf=%b empty=%b want a5/0/1", s_dout, s_unf, s_empty);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 8'(i));
            step(0, 1, 0, 8'h00);
            n_cmp++;
            if (s_dout !== exp_dout || s_dout !== 8'(i) || s_empty !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_%0d: sd=%h empty=%b want %h/1", i, s_dout, s_empty, exp_dout);
            end
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'hC0 + 8'(i));
        step(1, 1, 0, 8'h99);
        n_cmp++;
        if (s_count !== 3'd3 || s_dout !== 8'hC0 || s_ovf !== 1'b1 || f_dout !== 8'hC1) begin
            n_fail++;
            $display("FAIL full_wr_rd: count=%0d sd=%h ovf=%b fd=%h want 3/c0/1/c1",
                     s_count, s_dout, s_ovf, f_dout);
        end
        while (q.size() != 0) begin
            step(0, 1, 0, 8'h00);
            n_cmp++;
            if (s_dout !== exp_dout) begin
                n_fail++;
                $display("FAIL wrap_drain: sd=%h want %h", s_dout, exp_dout);
            end
        end
        step(0, 0, 1, 8'h00);
    endtask

    task automatic test_fwft();
        step(1, 0, 0, 8'h7E);
        n_cmp++;
        if (f_dout !== 8'h7E) begin
            n_fail++;
            $display("FAIL fwft_fall: fd=%h want 7e", f_dout);
        end
        step(1, 0, 0, 8'h3C);
        step(0, 1, 0, 8'h00);
        n_cmp++;
        if (f_dout !== 8'h3C || f_dout !== exp_head()) begin
            n_fail++;
            $display("FAIL fwft_next: fd=%h want 3c", f_dout);
        end
        step(0, 1, 0, 8'h00);
        n_cmp++;
        if (f_dout !== 8'h00 || f_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fwft_empty: fd=%h empty=%b want 00/1", f_dout, f_empty);
        end
    endtask

    task automatic test_async_reset();
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'hE0 + 8'(i));
        @(negedge clk);
        rst_n = 1'b0;
        q.delete(); exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
        #1;
        test_reset();
        #2;
        rst_n = 1'b1;
        step(1, 0, 0, 8'h01);
        step(0, 1, 0, 8'h00);
        n_cmp++;
        if (s_dout !== 8'h01 || s_empty !== 1'b1 || s_count !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset: sd=%h empty=%b count=%0d want 01/1/0", s_dout, s_empty, s_count);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
        rst_n = 1'b0; din_i = '0; wr_i = 1'b0; rd_i = 1'b0; clr_i = 1'b0;
        #2;
        test_reset();
        #10 rst_n = 1'b1;
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_fwft();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
